butterfly_pipe: RTL
===================

# butterfly_pipe

Parametrised, fully pipelined modular butterfly for the NTT/INTT datapath. It performs Cooley-Tukey and Gentleman-Sande butterflies, modular add/sub and modular multiply over a configurable odd modulus Q, with optional halving for INTT scaling. It sits between the coefficient-memory read ports and write-back. It carries opcode and a user tag through the pipeline, and uses valid/ready flow control with full-pipeline backpressure.

## Interface
- WIDTH, 12: coefficient width; Q < 2^WIDTH.
- Q, 3329: modulus; must be odd and > 2.
- MUL_LAT, 3: modular multiplier pipeline depth, ≥ 1.
- TAG_W, 8: width of the pass-through tag (write-back address/bank).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts input this cycle.
- op  in  2  operation: 0 CT, 1 GS, 2 ADDSUB, 3 MUL.
- halve  in  1  divide both results by 2 mod Q.
- a, b, w  in  WIDTH  operands and twiddle; each in [0,Q).
- tag  in  TAG_W  opaque; returned with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- e, o  out  WIDTH  results, in [0,Q).
- out_op  out  2  op of the presented result.
- out_tag  out  TAG_W  tag of the presented result.
- busy  out  1  any valid entry in the pipeline.

## Operation
- CT: t = b·w mod Q; e = a + t, o = a − t (mod Q).
- GS: e = a + b, o = (a − b)·w (mod Q).
- ADDSUB: e = a + b, o = a − b (mod Q); w is ignored.
- MUL: e = b·w mod Q, o = 0; a is ignored.
- halve=1, applied last to e and o: h(x) = x>>1 if x is even, else (x+Q)>>1.
- Add/sub are single conditional-correction stages. The multiplier produces a fully reduced result in [0,Q).
- Op, halve and tag travel in per-stage registers with the data. No control input is sampled after acceptance, so ops may change every cycle.
- Operands ≥ Q are illegal and give unspecified results. Assertions in the bench flag them.
- No FSM. State is the per-stage valid bits plus data/control registers.

## Timing
- Accept occurs on a cycle with in_valid && in_ready.
- advance = !(out_valid && !out_ready). in_ready = advance (combinational from out_ready).
- All stage registers, including the multiplier, load only when advance=1. A bubble (no accept) shifts in valid=0.
- Latency LAT = MUL_LAT + 3 cycles for every op: input reg, pre-add/sub, MUL_LAT mult stages, post-add/sub+halve. With MUL_LAT=3, LAT=6.
- CT and MUL route around the pre-add stage, and GS and ADDSUB around the post-add stage, through delay registers so that all ops share LAT. Results leave strictly in acceptance order.
- Throughput is 1 op/cycle when out_ready=1.
- While out_valid && !out_ready: e, o, out_op and out_tag stay stable, no accept occurs, and the pipeline holds.
- A result is consumed and a new input accepted in the same cycle when both handshakes fire.
- Reset: all valid bits clear immediately. out_valid=0, busy=0, e=o=0, out_op=0, out_tag=0. in_ready=1 once rst is low. In-flight ops are discarded.

## Structure
- Package butterfly_pkg: op encodings (OP_CT, OP_GS, OP_ADDSUB, OP_MUL), default WIDTH/Q, and the LAT function of MUL_LAT.
- Sub-module modmul_barrett (WIDTH, Q, MUL_LAT), with clk, rst, en, x, y, z. It is a Barrett reduction pipeline whose stages are gated by en.
- Modular add/sub and halve are local functions, not separate modules.

## Test plan
- CT, a=1, b=2, w=17, out_ready=1 → after 6 cycles e=35, o=3296, out_tag echoed.
- GS halve=1, a=3, b=2, w=1 → e=1667, o=1665. ADDSUB a=3328, b=2 → e=1, o=3326.
- MUL b=3328, w=3328 → e=1, o=0. MUL b=0, w=1234 → e=0.
- Issue 32 random mixed ops back-to-back with out_ready pattern 1,0,1,1,0,… → every result matches the reference model, in order, with none lost or duplicated; in_ready tracks advance; outputs are stable while stalled.
- Hold out_ready=0 with in_valid=1 → exactly LAT+1 ops accepted (pipeline and output full), then in_ready=0. Releasing out_ready drains all of them in order.
- Assert rst while 4 ops are in flight → out_valid=0 and busy=0 immediately. After release, a new op yields exactly one result, LAT cycles later.

Source files
------------

// File: rtl/butterfly_pkg.sv
// Shared definitions for the NTT/INTT butterfly datapath: op encodings,
// default field parameters and pipeline latency.
package butterfly_pkg;

    localparam logic [1:0] OP_CT     = 2'd0;
    localparam logic [1:0] OP_GS     = 2'd1;
    localparam logic [1:0] OP_ADDSUB = 2'd2;
    localparam logic [1:0] OP_MUL    = 2'd3;

    localparam int unsigned DEF_WIDTH   = 12;
    localparam int unsigned DEF_Q       = 3329;
    localparam int unsigned DEF_MUL_LAT = 3;

    // Accept edge to output-register load, identical for every op.
    function automatic int unsigned lat(input int unsigned mul_lat);
        return mul_lat + 3;
    endfunction

endpackage

// File: rtl/modmul_barrett.sv
// Pipelined modular multiplier z = x*y mod Q using Barrett reduction.
// The product is registered first; the reduction feeds the final stage.
module modmul_barrett #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned Q       = 3329,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [PW:0] R2K = {1'b1, {PW{1'b0}}};
    localparam logic [PW:0] MU  = R2K / (PW + 1)'(Q);

    // Quotient estimate is at most two short, so two corrections reach [0,Q).
    function automatic logic [WIDTH-1:0] reduce(input logic [PW-1:0] p);
        logic [2*PW-1:0] pm;
        logic [PW-1:0]   qe;
        logic [PW-1:0]   r;
        pm = (2 * PW)'(p) * (2 * PW)'(MU);
        qe = pm[2*PW-1:PW];
        r  = p - qe * PW'(Q);
        if (r >= PW'(Q)) r = r - PW'(Q);
        if (r >= PW'(Q)) r = r - PW'(Q);
        return r[WIDTH-1:0];
    endfunction

    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] z_q;

    assign prod = PW'(x) * PW'(y);
    assign z    = z_q;

    if (MUL_LAT == 1) begin : g_one
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                z_q <= '0;
            end else if (en) begin
                z_q <= reduce(prod);
            end
        end
    end else begin : g_multi
        logic [PW-1:0] p_q [MUL_LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < MUL_LAT - 1; i++) p_q[i] <= '0;
                z_q <= '0;
            end else if (en) begin
                p_q[0] <= prod;
                for (int i = 1; i < MUL_LAT - 1; i++) p_q[i] <= p_q[i-1];
                z_q <= reduce(p_q[MUL_LAT-2]);
            end
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Fully pipelined CT/GS/ADDSUB/MUL modular butterfly with optional halving,
// carrying op and tag alongside the data under full-pipeline backpressure.
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned Q       = DEF_Q,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             halve,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] w,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] o,
    output logic [1:0]       out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [WIDTH:0] QX = (WIDTH + 1)'(Q);

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX) s = s - QX;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) d = d + QX;
        return d[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_halve(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = x[0] ? {1'b0, x} + QX : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    logic advance;

    logic             s0_v, s0_h;
    logic [1:0]       s0_op;
    logic [TAG_W-1:0] s0_tag;
    logic [WIDTH-1:0] s0_a, s0_b, s0_w;

    logic             s1_v, s1_h;
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic [WIDTH-1:0] s1_e, s1_o, s1_w;

    // Delay line alongside the multiplier; index MUL_LAT-1 aligns with mul_z.
    logic [MUL_LAT-1:0] dl_v, dl_h;
    logic [1:0]         dl_op  [MUL_LAT];
    logic [TAG_W-1:0]   dl_tag [MUL_LAT];
    logic [WIDTH-1:0]   dl_e   [MUL_LAT];
    logic [WIDTH-1:0]   dl_o   [MUL_LAT];

    logic             s2_v;
    logic [1:0]       s2_op;
    logic [TAG_W-1:0] s2_tag;
    logic [WIDTH-1:0] s2_e, s2_o;

    logic [WIDTH-1:0] pre_e, pre_o, mul_z, sum_e, sum_o, post_e, post_o;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;
    assign busy     = s0_v | s1_v | (|dl_v) | s2_v | out_valid;

    // GS/ADDSUB form a+b and a-b here; CT/MUL pass a and b straight through.
    always_comb begin
        pre_e = s0_a;
        pre_o = s0_b;
        if (s0_op == OP_GS || s0_op == OP_ADDSUB) begin
            pre_e = mod_add(s0_a, s0_b);
            pre_o = mod_sub(s0_a, s0_b);
        end
    end

    modmul_barrett #(
        .WIDTH  (WIDTH),
        .Q      (Q),
        .MUL_LAT(MUL_LAT)
    ) u_mul (
        .clk(clk),
        .rst(rst),
        .en (advance),
        .x  (s1_o),
        .y  (s1_w),
        .z  (mul_z)
    );

    always_comb begin
        sum_e = '0;
        sum_o = '0;
        unique case (dl_op[MUL_LAT-1])
            OP_CT: begin
                sum_e = mod_add(dl_e[MUL_LAT-1], mul_z);
                sum_o = mod_sub(dl_e[MUL_LAT-1], mul_z);
            end
            OP_GS: begin
                sum_e = dl_e[MUL_LAT-1];
                sum_o = mul_z;
            end
            OP_ADDSUB: begin
                sum_e = dl_e[MUL_LAT-1];
                sum_o = dl_o[MUL_LAT-1];
            end
            OP_MUL: begin
                sum_e = mul_z;
                sum_o = '0;
            end
        endcase
        post_e = dl_h[MUL_LAT-1] ? mod_halve(sum_e) : sum_e;
        post_o = dl_h[MUL_LAT-1] ? mod_halve(sum_o) : sum_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s0_v, s0_h, s0_op, s0_tag, s0_a, s0_b, s0_w} <= '0;
            {s1_v, s1_h, s1_op, s1_tag, s1_e, s1_o, s1_w} <= '0;
            dl_v <= '0;
            dl_h <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                dl_op[i]  <= '0;
                dl_tag[i] <= '0;
                dl_e[i]   <= '0;
                dl_o[i]   <= '0;
            end
            {s2_v, s2_op, s2_tag, s2_e, s2_o} <= '0;
            {out_valid, out_op, out_tag, e, o} <= '0;
        end else if (advance) begin
            s0_v   <= in_valid;
            s0_h   <= halve;
            s0_op  <= op;
            s0_tag <= tag;
            s0_a   <= a;
            s0_b   <= b;
            s0_w   <= w;

            s1_v   <= s0_v;
            s1_h   <= s0_h;
            s1_op  <= s0_op;
            s1_tag <= s0_tag;
            s1_e   <= pre_e;
            s1_o   <= pre_o;
            s1_w   <= s0_w;

            dl_v[0]   <= s1_v;
            dl_h[0]   <= s1_h;
            dl_op[0]  <= s1_op;
            dl_tag[0] <= s1_tag;
            dl_e[0]   <= s1_e;
            dl_o[0]   <= s1_o;
            for (int i = 1; i < MUL_LAT; i++) begin
                dl_v[i]   <= dl_v[i-1];
                dl_h[i]   <= dl_h[i-1];
                dl_op[i]  <= dl_op[i-1];
                dl_tag[i] <= dl_tag[i-1];
                dl_e[i]   <= dl_e[i-1];
                dl_o[i]   <= dl_o[i-1];
            end

            s2_v   <= dl_v[MUL_LAT-1];
            s2_op  <= dl_op[MUL_LAT-1];
            s2_tag <= dl_tag[MUL_LAT-1];
            s2_e   <= post_e;
            s2_o   <= post_o;

            out_valid <= s2_v;
            out_op    <= s2_op;
            out_tag   <= s2_tag;
            e         <= s2_e;
            o         <= s2_o;
        end
    end

endmodule
